// File: rtl/rf_ctx_pkg.sv
// Shared types and defaults for the register-file context save/restore engine.
package rf_ctx_pkg;

  localparam int NUM_REGS_DEF = 8;
  localparam int WIDTH_DEF    = 16;
  localparam int IDX_W        = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    S_FETCH = 3'd1,
    S_SEND  = 3'd2,
    R_RECV  = 3'd3,
    DONE    = 3'd4
  } ctxState_e;

endpackage

// File: rtl/rf_ctx_cnt.sv
// Register index counter: clears at operation start, saturates at the last register.
module rf_ctx_cnt
  import rf_ctx_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  logic [IDX_W-1:0] idx_r;

  // index register; never steps past LAST_IDX so no wrap inside an operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r <= '0;
    end else if (clr) begin
      idx_r <= '0;
    end else if (inc && !last) begin
      idx_r <= idx_r + 3'd1;
    end else begin
      idx_r <= idx_r;
    end
  end

  assign idx  = idx_r;
  assign last = (idx_r == LAST_IDX);

endmodule

// File: rtl/rf_ctx_engine.sv
// Context engine: dumps the register file onto a stream (save) or refills it
// from a stream (restore), one register per handshake, in ascending order.
module rf_ctx_engine
  import rf_ctx_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int WIDTH    = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             save_req,
  input  logic             restore_req,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] dout_data,
  output logic             dout_valid,
  input  logic             dout_ready,
  input  logic [WIDTH-1:0] din_data,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [IDX_W-1:0] rf_readSel,
  input  logic [WIDTH-1:0] rf_readData,
  output logic [IDX_W-1:0] rf_writeSel,
  output logic [WIDTH-1:0] rf_writeData,
  output logic             rf_writeEn
);

  ctxState_e        state_r;
  ctxState_e        flowNext_s;
  ctxState_e        stateNext_s;
  logic [WIDTH-1:0] holdData_r;
  logic             err_r;
  logic             errNext_s;
  logic             idxClr_s;
  logic             idxInc_s;
  logic [IDX_W-1:0] idx_s;
  logic             last_s;
  logic             sendHs_s;
  logic             recvHs_s;

  rf_ctx_cnt #(
    .NUM_REGS (NUM_REGS)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (idxClr_s),
    .inc   (idxInc_s),
    .idx   (idx_s),
    .last  (last_s)
  );

  assign sendHs_s = (state_r == S_SEND) && dout_ready;
  assign recvHs_s = (state_r == R_RECV) && din_valid;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // next-state and index control; abort overrides the normal flow but the
  // handshake of the same cycle still transfers (outputs are state-decoded)
  always_comb begin
    flowNext_s = state_r;
    idxClr_s   = 1'b0;
    idxInc_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (save_req) begin
          flowNext_s = S_FETCH;
          idxClr_s   = 1'b1;
        end else if (restore_req) begin
          flowNext_s = R_RECV;
          idxClr_s   = 1'b1;
        end else begin
          flowNext_s = IDLE;
        end
      end
      S_FETCH: flowNext_s = S_SEND;
      S_SEND: begin
        if (sendHs_s) begin
          if (last_s) begin
            flowNext_s = DONE;
          end else begin
            flowNext_s = S_FETCH;
            idxInc_s   = 1'b1;
          end
        end else begin
          flowNext_s = S_SEND;
        end
      end
      R_RECV: begin
        if (recvHs_s) begin
          if (last_s) begin
            flowNext_s = DONE;
          end else begin
            flowNext_s = R_RECV;
            idxInc_s   = 1'b1;
          end
        end else begin
          flowNext_s = R_RECV;
        end
      end
      DONE:    flowNext_s = IDLE;
      default: flowNext_s = IDLE;
    endcase
    if (abort && (state_r != IDLE)) begin
      stateNext_s = IDLE;
    end else begin
      stateNext_s = flowNext_s;
    end
  end

  // protocol error: simultaneous requests in IDLE, or any request while busy
  always_comb begin
    if (state_r == IDLE) begin
      errNext_s = save_req && restore_req;
    end else begin
      errNext_s = save_req || restore_req;
    end
  end

  // holding register for the outgoing word and registered error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holdData_r <= '0;
      err_r      <= 1'b0;
    end else begin
      err_r <= errNext_s;
      if (state_r == S_FETCH) begin
        holdData_r <= rf_readData;
      end else begin
        holdData_r <= holdData_r;
      end
    end
  end

  // output decode from state; everything idles at zero
  always_comb begin
    busy         = (state_r != IDLE);
    done         = 1'b0;
    dout_valid   = 1'b0;
    dout_data    = '0;
    din_ready    = 1'b0;
    rf_readSel   = '0;
    rf_writeSel  = '0;
    rf_writeData = '0;
    rf_writeEn   = 1'b0;
    case (state_r)
      S_FETCH: rf_readSel = idx_s;
      S_SEND: begin
        dout_valid = 1'b1;
        dout_data  = holdData_r;
      end
      R_RECV: begin
        din_ready    = 1'b1;
        rf_writeSel  = idx_s;
        rf_writeData = din_data;
        rf_writeEn   = din_valid;
      end
      DONE:    done = 1'b1;
      default: done = 1'b0;
    endcase
  end

  assign err = err_r;

endmodule

// File: tb/tb_rf_ctx_engine.sv
// Directed self-checking bench for rf_ctx_engine with a behavioural register file.
module tb_rf_ctx_engine;

  logic        clk;
  logic        rst_n;
  logic        save_req, restore_req, abort;
  logic        busy, done, err;
  logic [15:0] dout_data;
  logic        dout_valid, dout_ready;
  logic [15:0] din_data;
  logic        din_valid, din_ready;
  logic [2:0]  rf_readSel, rf_writeSel;
  logic [15:0] rf_readData, rf_writeData;
  logic        rf_writeEn;

  logic [15:0] rfMem [8];
  logic        loadEn;
  logic [2:0]  loadSel;
  logic [15:0] loadData;

  int errCnt = 0;
  int chkCnt = 0;

  rf_ctx_engine dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .save_req     (save_req),
    .restore_req  (restore_req),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .dout_data    (dout_data),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .din_data     (din_data),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .rf_readSel   (rf_readSel),
    .rf_readData  (rf_readData),
    .rf_writeSel  (rf_writeSel),
    .rf_writeData (rf_writeData),
    .rf_writeEn   (rf_writeEn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rf_readData = rfMem[rf_readSel];

  always @(posedge clk) begin
    if (loadEn) begin
      rfMem[loadSel] <= loadData;
    end else if (rf_writeEn) begin
      rfMem[rf_writeSel] <= rf_writeData;
    end
  end

  task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    chkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic preload(input logic [15:0] base);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      loadEn   = 1'b1;
      loadSel  = 3'(i);
      loadData = base + 16'(i);
    end
    @(negedge clk);
    loadEn = 1'b0;
  endtask

  task automatic doSave(input logic both, input logic slow, input logic [15:0] base, input int expDone);
    int          n;
    int          doneCyc;
    logic        prevStall;
    logic [15:0] prevData;
    n = 0; doneCyc = 0; prevStall = 1'b0; prevData = 16'h0000;
    @(negedge clk);
    save_req    = 1'b1;
    restore_req = both;
    @(negedge clk);
    save_req    = 1'b0;
    restore_req = 1'b0;
    for (int c = 1; c <= 80 && doneCyc == 0; c++) begin
      dout_ready = slow ? (((c / 2) % 2) == 0) : 1'b1;
      #1;
      if (c == 1) checkVal("errCmd", 16'(err), 16'(both));
      if (c == 1) checkVal("saveNotRestore", 16'(din_ready), 16'h0000);
      if (c == 2) checkVal("errPulse", 16'(err), 16'h0000);
      if (prevStall && dout_valid) checkVal("holdStable", dout_data, prevData);
      if (dout_valid && dout_ready) begin
        checkVal("dumpWord", dout_data, base + 16'(n));
        n++;
      end
      if (done) doneCyc = c;
      prevStall = dout_valid && !dout_ready;
      prevData  = dout_data;
      @(negedge clk);
    end
    dout_ready = 1'b0;
    checkVal("dumpDone", 16'(doneCyc), 16'(expDone));
    checkVal("dumpCount", 16'(n), 16'd8);
    checkVal("busyAfterSave", 16'(busy), 16'h0000);
  endtask

  task automatic doRestore(input logic [15:0] base, input int abortAt, input int saveAt, input int expDone);
    int k;
    int doneCyc;
    bit aborted;
    k = 0; doneCyc = 0; aborted = 1'b0;
    @(negedge clk);
    restore_req = 1'b1;
    @(negedge clk);
    restore_req = 1'b0;
    din_valid   = 1'b1;
    for (int c = 1; c <= 40 && doneCyc == 0 && !aborted; c++) begin
      din_data = base + 16'(k);
      save_req = (c == saveAt);
      abort    = (abortAt != 0) && (k == abortAt - 1);
      #1;
      if (c == 1) checkVal("dinReady", 16'(din_ready), 16'h0001);
      if (saveAt != 0 && c == saveAt + 1) checkVal("errBusy", 16'(err), 16'h0001);
      if (saveAt != 0 && c == saveAt + 2) checkVal("errBusyOnce", 16'(err), 16'h0000);
      if (rf_writeEn) begin
        checkVal("wSel", 16'(rf_writeSel), 16'(k));
        checkVal("wData", rf_writeData, base + 16'(k));
        k++;
      end
      if (done) doneCyc = c;
      aborted = abort;
      @(negedge clk);
    end
    save_req  = 1'b0;
    abort     = 1'b0;
    din_valid = 1'b0;
    if (abortAt != 0) begin
      checkVal("abortBusy", 16'(busy), 16'h0000);
      checkVal("abortNoDone", 16'(done), 16'h0000);
      checkVal("abortNoDoneSeen", 16'(doneCyc), 16'h0000);
      checkVal("abortWrites", 16'(k), 16'(abortAt));
    end else begin
      checkVal("restoreDone", 16'(doneCyc), 16'(expDone));
      checkVal("restoreWrites", 16'(k), 16'd8);
      checkVal("busyAfterRestore", 16'(busy), 16'h0000);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; save_req = 1'b0; restore_req = 1'b0; abort = 1'b0;
    dout_ready = 1'b0; din_data = 16'h0000; din_valid = 1'b0;
    loadEn = 1'b0; loadSel = 3'd0; loadData = 16'h0000;
    #2;
    checkVal("rstBusy", 16'(busy), 16'h0000);
    checkVal("rstDone", 16'(done), 16'h0000);
    checkVal("rstErr", 16'(err), 16'h0000);
    checkVal("rstDoutValid", 16'(dout_valid), 16'h0000);
    checkVal("rstDoutData", dout_data, 16'h0000);
    checkVal("rstDinReady", 16'(din_ready), 16'h0000);
    checkVal("rstWriteEn", 16'(rf_writeEn), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkVal("idleBusy", 16'(busy), 16'h0000);

    preload(16'h1000);
    doSave(1'b0, 1'b0, 16'h1000, 17);
    doSave(1'b0, 1'b1, 16'h1000, 33);

    doRestore(16'hA5A0, 0, 0, 9);
    for (int i = 0; i < 8; i++) checkVal("rfAfterRestore", rfMem[i], 16'hA5A0 + 16'(i));

    doSave(1'b1, 1'b0, 16'hA5A0, 17);

    doRestore(16'hB000, 0, 3, 9);
    for (int i = 0; i < 8; i++) checkVal("rfAfterBusyReq", rfMem[i], 16'hB000 + 16'(i));

    doRestore(16'hC000, 3, 0, 0);
    for (int i = 0; i < 8; i++)
      checkVal("rfAfterAbort", rfMem[i], (i < 3) ? (16'hC000 + 16'(i)) : (16'hB000 + 16'(i)));

    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkVal("abortIdle", 16'(busy), 16'h0000);
    checkVal("abortIdleErr", 16'(err), 16'h0000);

    preload(16'h2000);
    @(negedge clk);
    save_req   = 1'b1;
    dout_ready = 1'b1;
    @(negedge clk);
    save_req = 1'b0;
    repeat (5) @(negedge clk);
    checkVal("midDumpBusy", 16'(busy), 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("asyncRstBusy", 16'(busy), 16'h0000);
    checkVal("asyncRstValid", 16'(dout_valid), 16'h0000);
    checkVal("asyncRstData", dout_data, 16'h0000);
    checkVal("asyncRstReadSel", 16'(rf_readSel), 16'h0000);
    checkVal("asyncRstWriteEn", 16'(rf_writeEn), 16'h0000);
    checkVal("asyncRstDone", 16'(done), 16'h0000);
    #4;
    rst_n = 1'b1;
    dout_ready = 1'b0;
    @(negedge clk);
    checkVal("postRstIdle", 16'(busy), 16'h0000);
    doSave(1'b0, 1'b0, 16'h2000, 17);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
